// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core (one ALU, one memory port, one register file).
// Defining CTRL_PERF_CNT_EN adds the cycle_cnt_o / instret_cnt_o performance counters.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        adr_src_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic        reg_we_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  result_src_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic [3:0]  state_dbg_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instret_cnt_o
`endif
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ALU_WB  = 4'd4,
    S_MEM_ADR = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WB  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_BRANCH  = 4'd9,
    S_TRAP    = 4'd10
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [8:0] TimeoutLim = 9'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic        busErr_q, busErr_d;
  logic [7:0]  waitCnt_q, waitCnt_d;

  logic        memReq, memWe, adrSrc, irWe, pcWe, regWe;
  logic [1:0]  aluSrcA, aluSrcB, aluOp, resultSrc;
  logic [8:0]  waitNext;
  logic        waitExpired;

  // The current wait cycle is the MEM_TIMEOUT-th one; a ready in the same cycle still wins.
  assign waitNext    = {1'b0, waitCnt_q} + 9'd1;
  assign waitExpired = (TimeoutLim != 9'd0) && (waitNext >= TimeoutLim);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      busErr_q  <= 1'b0;
      waitCnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      busErr_q  <= busErr_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    busErr_d  = busErr_q;
    memReq    = 1'b0;
    memWe     = 1'b0;
    adrSrc    = 1'b0;
    irWe      = 1'b0;
    pcWe      = 1'b0;
    regWe     = 1'b0;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    resultSrc = 2'b00;

    case (state_q)
      S_FETCH: begin
        memReq    = 1'b1;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        if (mem_ready_i) begin
          irWe    = 1'b1;
          pcWe    = 1'b1;
          state_d = S_DECODE;
        end else if (waitExpired) begin
          busErr_d = 1'b1;
          state_d  = S_TRAP;
        end
      end

      S_DECODE: begin
        // Branch target PC+imm is computed here so BRANCH only needs the compare.
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (opcode_i)
          OP_R:     state_d = S_EXEC_R;
          OP_I:     state_d = S_EXEC_I;
          OP_LOAD,
          OP_STORE: state_d = S_MEM_ADR;
          OP_BRANCH: begin
            if (funct3_i == 3'b000 || funct3_i == 3'b001) begin
              state_d = S_BRANCH;
            end else begin
              illegal_d = 1'b1;
              state_d   = S_TRAP;
            end
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end
        endcase
      end

      S_EXEC_R: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
        state_d = S_ALU_WB;
      end

      S_EXEC_I: begin
        // ADDI must not let imm[11:5] be decoded as funct7, so force a plain ADD.
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = (funct3_i == 3'b000) ? 2'b00 : 2'b11;
        state_d = S_ALU_WB;
      end

      S_ALU_WB: begin
        regWe   = 1'b1;
        state_d = S_FETCH;
      end

      S_MEM_ADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        state_d = (opcode_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        memReq = 1'b1;
        adrSrc = 1'b1;
        if (mem_ready_i) begin
          state_d = S_MEM_WB;
        end else if (waitExpired) begin
          busErr_d = 1'b1;
          state_d  = S_TRAP;
        end
      end

      S_MEM_WB: begin
        regWe     = 1'b1;
        resultSrc = 2'b01;
        state_d   = S_FETCH;
      end

      S_MEM_WR: begin
        memReq = 1'b1;
        memWe  = 1'b1;
        adrSrc = 1'b1;
        if (mem_ready_i) begin
          state_d = S_FETCH;
        end else if (waitExpired) begin
          busErr_d = 1'b1;
          state_d  = S_TRAP;
        end
      end

      S_BRANCH: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b01;
        pcWe    = (funct3_i == 3'b000) ? zero_i : ~zero_i;
        state_d = S_FETCH;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // Every state change clears the wait counter, which covers entry into FETCH/MEM_RD/MEM_WR.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (state_d != state_q) begin
      waitCnt_d = 8'd0;
    end else if (memReq && !mem_ready_i && waitCnt_q != 8'hFF) begin
      waitCnt_d = waitCnt_q + 8'd1;
    end
  end

  assign mem_req_o    = rst_ni & memReq;
  assign mem_we_o     = rst_ni & memWe;
  assign adr_src_o    = rst_ni & adrSrc;
  assign ir_we_o      = rst_ni & irWe;
  assign pc_we_o      = rst_ni & pcWe;
  assign reg_we_o     = rst_ni & regWe;
  assign alu_src_a_o  = rst_ni ? aluSrcA : 2'b00;
  assign alu_src_b_o  = rst_ni ? aluSrcB : 2'b00;
  assign alu_op_o     = rst_ni ? aluOp : 2'b00;
  assign result_src_o = rst_ni ? resultSrc : 2'b00;
  assign illegal_o    = rst_ni & illegal_q;
  assign bus_err_o    = rst_ni & busErr_q;
  assign state_dbg_o  = rst_ni ? state_q : 4'd0;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycleCnt_q, instretCnt_q;
  logic        retire;

  // An instruction retires when control returns to FETCH from one of its final states.
  assign retire = (state_d == S_FETCH) &&
                  (state_q == S_ALU_WB || state_q == S_MEM_WB ||
                   state_q == S_MEM_WR || state_q == S_BRANCH);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cycleCnt_q   <= 32'd0;
      instretCnt_q <= 32'd0;
    end else begin
      if (state_q != S_TRAP) begin
        cycleCnt_q <= cycleCnt_q + 32'd1;
      end
      if (retire) begin
        instretCnt_q <= instretCnt_q + 32'd1;
      end
    end
  end

  assign cycle_cnt_o   = rst_ni ? cycleCnt_q : 32'd0;
  assign instret_cnt_o = rst_ni ? instretCnt_q : 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: drives two controllers (MEM_TIMEOUT=4 and MEM_TIMEOUT=0) against a per-instruction
// cycle-trace model built from the instruction-class rules; randomized instruction mix plus directed corner cases.
module tb_multicycle_ctrl;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
                         S_ALU_WB = 4'd4, S_MEM_ADR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WB = 4'd7,
                         S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_TRAP = 4'd10;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BR = 7'b1100011;

  typedef struct packed {
    logic        ready;
    logic        zero;
    logic [19:0] vec;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n, zero, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;

  logic memReq, memWe, adrSrc, irWe, pcWe, regWe, illegal, busErr;
  logic [1:0] aluSrcA, aluSrcB, aluOp, resultSrc;
  logic [3:0] stateDbg;
  logic memReq0, memWe0, adrSrc0, irWe0, pcWe0, regWe0, illegal0, busErr0;
  logic [1:0] aluSrcA0, aluSrcB0, aluOp0, resultSrc0;
  logic [3:0] stateDbg0;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycleCnt, instretCnt, cycleCnt0, instretCnt0;
`endif

  logic [19:0] obsVec, obsVec0;
  cyc_t        plan[$];
  logic [6:0]  planOp;
  logic [2:0]  planF3;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .funct3_i(funct3), .zero_i(zero),
    .mem_ready_i(mem_ready), .mem_req_o(memReq), .mem_we_o(memWe), .adr_src_o(adrSrc),
    .ir_we_o(irWe), .pc_we_o(pcWe), .reg_we_o(regWe), .alu_src_a_o(aluSrcA),
    .alu_src_b_o(aluSrcB), .alu_op_o(aluOp), .result_src_o(resultSrc), .illegal_o(illegal),
    .bus_err_o(busErr), .state_dbg_o(stateDbg)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt_o(cycleCnt), .instret_cnt_o(instretCnt)
`endif
  );

  multicycle_ctrl #(.MEM_TIMEOUT(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .funct3_i(funct3), .zero_i(zero),
    .mem_ready_i(mem_ready), .mem_req_o(memReq0), .mem_we_o(memWe0), .adr_src_o(adrSrc0),
    .ir_we_o(irWe0), .pc_we_o(pcWe0), .reg_we_o(regWe0), .alu_src_a_o(aluSrcA0),
    .alu_src_b_o(aluSrcB0), .alu_op_o(aluOp0), .result_src_o(resultSrc0), .illegal_o(illegal0),
    .bus_err_o(busErr0), .state_dbg_o(stateDbg0)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt_o(cycleCnt0), .instret_cnt_o(instretCnt0)
`endif
  );

  assign obsVec  = {stateDbg, memReq, memWe, adrSrc, irWe, pcWe, regWe,
                    aluSrcA, aluSrcB, aluOp, resultSrc, illegal, busErr};
  assign obsVec0 = {stateDbg0, memReq0, memWe0, adrSrc0, irWe0, pcWe0, regWe0,
                    aluSrcA0, aluSrcB0, aluOp0, resultSrc0, illegal0, busErr0};

  function automatic logic [19:0] pack(input logic [3:0] st, input logic mr, mw, as, iw, pw, rw,
                                       input logic [1:0] a, b, op, rs, input logic il, be);
    return {st, mr, mw, as, iw, pw, rw, a, b, op, rs, il, be};
  endfunction

  task automatic addCyc(input logic rdy, input logic zr, input logic [19:0] v);
    cyc_t c;
    c.ready = rdy;
    c.zero  = zr;
    c.vec   = v;
    plan.push_back(c);
  endtask

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference trace: one entry per clock for a whole instruction, derived from the instruction-class table.
  task automatic build_plan(input logic [6:0] op, input logic [2:0] f3, input logic z,
                            input int fw, input int mw, output bit trapped);
    plan.delete();
    planOp  = op;
    planF3  = f3;
    trapped = 1'b0;
    for (int i = 0; i < fw; i++)
      addCyc(1'b0, rnd1(), pack(S_FETCH, 1,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 0,0));
    addCyc(1'b1, rnd1(), pack(S_FETCH, 1,0,0,1,1,0, 2'b00, 2'b10, 2'b00, 2'b10, 0,0));
    addCyc(rnd1(), rnd1(), pack(S_DECODE, 0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 2'b00, 0,0));
    case (op)
      OP_R: begin
        addCyc(rnd1(), rnd1(), pack(S_EXEC_R, 0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 0,0));
        addCyc(rnd1(), rnd1(), pack(S_ALU_WB, 0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 0,0));
      end
      OP_I: begin
        addCyc(rnd1(), rnd1(), pack(S_EXEC_I, 0,0,0,0,0,0, 2'b10, 2'b01,
                                    (f3 == 3'b000) ? 2'b00 : 2'b11, 2'b00, 0,0));
        addCyc(rnd1(), rnd1(), pack(S_ALU_WB, 0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 0,0));
      end
      OP_LW: begin
        addCyc(rnd1(), rnd1(), pack(S_MEM_ADR, 0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b00, 0,0));
        for (int i = 0; i <= mw; i++)
          addCyc(i == mw, rnd1(), pack(S_MEM_RD, 1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0));
        addCyc(rnd1(), rnd1(), pack(S_MEM_WB, 0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b01, 0,0));
      end
      OP_SW: begin
        addCyc(rnd1(), rnd1(), pack(S_MEM_ADR, 0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b00, 0,0));
        for (int i = 0; i <= mw; i++)
          addCyc(i == mw, rnd1(), pack(S_MEM_WR, 1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0));
      end
      OP_BR: begin
        if (f3 == 3'b000 || f3 == 3'b001)
          addCyc(rnd1(), z, pack(S_BRANCH, 0,0,0,0, (f3 == 3'b000) ? z : !z, 0,
                                 2'b10, 2'b00, 2'b01, 2'b00, 0,0));
        else
          trapped = 1'b1;
      end
      default: trapped = 1'b1;
    endcase
    if (trapped) begin
      addCyc(rnd1(), rnd1(), pack(S_TRAP, 0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 1,0));
      addCyc(rnd1(), rnd1(), pack(S_TRAP, 0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 1,0));
    end
  endtask

  task automatic run_plan(input string name, input bit checkDut0);
    foreach (plan[k]) begin
      @(negedge clk);
      if (k == 0) begin
        opcode = planOp;
        funct3 = planF3;
      end
      mem_ready = plan[k].ready;
      zero      = plan[k].zero;
      #1;
      compared++;
      if (obsVec !== plan[k].vec) begin
        mismatched++;
        $display("[TB] FAIL %s cyc%0d (to=4): got %h expected %h", name, k, obsVec, plan[k].vec);
      end
      if (checkDut0) begin
        compared++;
        if (obsVec0 !== plan[k].vec) begin
          mismatched++;
          $display("[TB] FAIL %s cyc%0d (to=0): got %h expected %h", name, k, obsVec0, plan[k].vec);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    #1;
    compared += 2;
    if (obsVec !== 20'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs (to=4): got %h expected %h", obsVec, 20'h0);
    end
    if (obsVec0 !== 20'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs (to=0): got %h expected %h", obsVec0, 20'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bit t;
    do_reset();
    build_plan(OP_R, 3'b000, 1'b0, 2, 0, t);
    run_plan("reset_then_fetch", 1'b1);
  endtask

  task automatic test_alu();
    bit t;
    build_plan(OP_R, 3'b000, 1'b0, 0, 0, t);
    run_plan("r_add", 1'b1);
    build_plan(OP_I, 3'b000, 1'b0, 0, 0, t);
    run_plan("addi", 1'b1);
    build_plan(OP_I, 3'b110, 1'b0, 1, 0, t);
    run_plan("ori", 1'b1);
  endtask

  task automatic test_mem();
    bit t;
    build_plan(OP_LW, 3'b010, 1'b0, 0, 3, t);
    run_plan("lw_wait3", 1'b1);
    build_plan(OP_SW, 3'b010, 1'b0, 0, 0, t);
    run_plan("sw", 1'b1);
  endtask

  task automatic test_branch();
    bit t;
    build_plan(OP_BR, 3'b000, 1'b1, 0, 0, t);
    run_plan("beq_taken", 1'b1);
    build_plan(OP_BR, 3'b001, 1'b1, 0, 0, t);
    run_plan("bne_not_taken", 1'b1);
    build_plan(OP_BR, 3'b100, 1'b0, 0, 0, t);
    run_plan("branch_f3_100_trap", 1'b1);
    do_reset();
    build_plan(OP_I, 3'b111, 1'b0, 0, 0, t);
    run_plan("after_trap_reset", 1'b1);
  endtask

  task automatic test_timeout();
    bit t;
    // Fetch never completes: the to=4 controller traps, the to=0 one keeps waiting.
    plan.delete();
    planOp = OP_R;
    planF3 = 3'b000;
    for (int i = 0; i < 4; i++)
      addCyc(1'b0, 1'b0, pack(S_FETCH, 1,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 0,0));
    addCyc(1'b0, 1'b0, pack(S_TRAP, 0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,1));
    addCyc(1'b1, 1'b0, pack(S_TRAP, 0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,1));
    run_plan("fetch_timeout", 1'b0);
    compared++;
    if (obsVec0 !== pack(S_FETCH, 1,0,0,1,1,0, 2'b00, 2'b10, 2'b00, 2'b10, 0,0)) begin
      mismatched++;
      $display("[TB] FAIL no_timeout_when_0: got %h expected %h", obsVec0,
               pack(S_FETCH, 1,0,0,1,1,0, 2'b00, 2'b10, 2'b00, 2'b10, 0,0));
    end
    do_reset();
    build_plan(OP_R, 3'b000, 1'b0, 3, 0, t);
    run_plan("ready_in_4th_wait", 1'b1);
    // Store whose write never completes.
    plan.delete();
    planOp = OP_SW;
    planF3 = 3'b010;
    addCyc(1'b1, 1'b0, pack(S_FETCH, 1,0,0,1,1,0, 2'b00, 2'b10, 2'b00, 2'b10, 0,0));
    addCyc(1'b0, 1'b0, pack(S_DECODE, 0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 2'b00, 0,0));
    addCyc(1'b0, 1'b0, pack(S_MEM_ADR, 0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b00, 0,0));
    for (int i = 0; i < 4; i++)
      addCyc(1'b0, 1'b0, pack(S_MEM_WR, 1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0));
    addCyc(1'b0, 1'b0, pack(S_TRAP, 0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,1));
    run_plan("store_timeout", 1'b0);
    compared++;
    if (obsVec0 !== pack(S_MEM_WR, 1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0)) begin
      mismatched++;
      $display("[TB] FAIL store_wait_when_0: got %h expected %h", obsVec0,
               pack(S_MEM_WR, 1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0));
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    bit t;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      build_plan(OP_R, 3'b000, 1'b0, 0, 0, t);
      run_plan("b2b_add", 1'b1);
    end
    @(posedge clk);
    #1;
`ifdef CTRL_PERF_CNT_EN
    compared += 2;
    if (instretCnt !== 32'd10) begin
      mismatched++;
      $display("[TB] FAIL instret_cnt: got %0d expected 10", instretCnt);
    end
    if (cycleCnt !== 32'd40) begin
      mismatched++;
      $display("[TB] FAIL cycle_cnt: got %0d expected 40", cycleCnt);
    end
`endif
  endtask

  task automatic test_random();
    bit t;
    logic [6:0] op;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LW;
        3: op = OP_SW;
        4: op = OP_BR;
        default: op = 7'($urandom);
      endcase
      build_plan(op, 3'($urandom), rnd1(), $urandom_range(0, 3), $urandom_range(0, 3), t);
      run_plan("random", 1'b1);
      if (t) do_reset();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    opcode    = 7'd0;
    funct3    = 3'd0;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
